// File: rtl/elevator_car_ctrl.sv
// Elevator car controller for floors 0..4: directional hall-call service with
// timed one-floor travel, a one-cycle arrival decision and a timed door dwell.
module elevator_car_ctrl #(
    parameter int MOVE_CYCLES = 8,
    parameter int DOOR_CYCLES = 6
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] Up_Queue,
    input  logic [4:0] Down_Queue,
    output logic [4:0] Up_Clear,
    output logic [4:0] Down_Clear,
    output logic [2:0] Floor,
    output logic [1:0] Dir,
    output logic       Door_Open,
    output logic       Moving
);
    // state  | meaning
    // IDLE   | parked with door closed, waiting for a call
    // MOVE   | travelling one floor, move timer counting down
    // ARRIVE | single-cycle stop/continue decision at the new floor
    // DOOR   | door open at the current floor, dwell timer counting down
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVE   = 2'd1,
        S_ARRIVE = 2'd2,
        S_DOOR   = 2'd3
    } state_t;

    localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MOVE_LOAD = CW'(MOVE_CYCLES - 1);
    localparam logic [CW-1:0] DOOR_LOAD = CW'(DOOR_CYCLES - 1);
    localparam logic [1:0] DIR_IDLE  = 2'b00;
    localparam logic [1:0] DIR_UP    = 2'b01;
    localparam logic [1:0] DIR_DN    = 2'b10;
    localparam logic [2:0] TOP_FLOOR = 3'd4;

    state_t        state_q, state_n;
    logic [CW-1:0] move_cnt_q, move_cnt_n;
    logic [CW-1:0] door_cnt_q, door_cnt_n;
    logic [2:0]    floor_n;
    logic [1:0]    dir_n;
    logic [4:0]    up_clr_n, dn_clr_n;
    logic          mask_q;
    logic [4:0]    req, floor_bit;
    logic          above, below, here, up_here, dn_here;
    logic          stop, open_door, go_up, go_dn;

    always_comb begin
        req   = Up_Queue | Down_Queue;
        above = 1'b0;
        below = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (req[k] && (3'(k) > Floor)) above = 1'b1;
            if (req[k] && (3'(k) < Floor)) below = 1'b1;
        end
        floor_bit = 5'b00001 << Floor;
        up_here   = |(Up_Queue & floor_bit);
        dn_here   = |(Down_Queue & floor_bit);
        // The queue owner drops a cleared bit late, so the current floor is
        // ignored while a pulse is out and for the cycle after it.
        here      = (up_here || dn_here) && !mask_q;
    end

    always_comb begin
        state_n    = state_q;
        floor_n    = Floor;
        dir_n      = Dir;
        move_cnt_n = move_cnt_q;
        door_cnt_n = door_cnt_q;
        up_clr_n   = '0;
        dn_clr_n   = '0;
        stop       = 1'b0;
        open_door  = 1'b0;
        go_up      = 1'b0;
        go_dn      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (here)       open_door = 1'b1;
                else if (above) go_up     = 1'b1;
                else if (below) go_dn     = 1'b1;
                else            dir_n     = DIR_IDLE;
            end
            S_MOVE: begin
                if (move_cnt_q == '0) begin
                    if (Dir == DIR_UP && Floor != TOP_FLOOR)  floor_n = Floor + 3'd1;
                    else if (Dir == DIR_DN && Floor != 3'd0)  floor_n = Floor - 3'd1;
                    state_n = S_ARRIVE;
                end else begin
                    move_cnt_n = move_cnt_q - 1'b1;
                end
            end
            S_ARRIVE: begin
                if (Dir == DIR_UP)
                    stop = up_here || (dn_here && !above) || (Floor == TOP_FLOOR);
                else if (Dir == DIR_DN)
                    stop = dn_here || (up_here && !below) || (Floor == 3'd0);
                else
                    stop = 1'b1;
                if (!stop) begin
                    state_n    = S_MOVE;
                    move_cnt_n = MOVE_LOAD;
                end else if (here) begin
                    open_door = 1'b1;
                end else begin
                    state_n = S_IDLE;
                    dir_n   = DIR_IDLE;
                end
            end
            S_DOOR: begin
                if (here) begin
                    open_door = 1'b1;
                end else if (door_cnt_q != '0) begin
                    door_cnt_n = door_cnt_q - 1'b1;
                end else if (Dir == DIR_DN) begin
                    if (below)      go_dn = 1'b1;
                    else if (above) go_up = 1'b1;
                    else begin
                        state_n = S_IDLE;
                        dir_n   = DIR_IDLE;
                    end
                end else begin
                    if (above)      go_up = 1'b1;
                    else if (below) go_dn = 1'b1;
                    else begin
                        state_n = S_IDLE;
                        dir_n   = DIR_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (open_door) begin
            state_n    = S_DOOR;
            door_cnt_n = DOOR_LOAD;
            up_clr_n   = Up_Queue & floor_bit;
            dn_clr_n   = Down_Queue & floor_bit;
        end
        if (go_up) begin
            state_n    = S_MOVE;
            dir_n      = DIR_UP;
            move_cnt_n = MOVE_LOAD;
        end
        if (go_dn) begin
            state_n    = S_MOVE;
            dir_n      = DIR_DN;
            move_cnt_n = MOVE_LOAD;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            Floor      <= 3'd0;
            Dir        <= DIR_IDLE;
            move_cnt_q <= '0;
            door_cnt_q <= '0;
            Up_Clear   <= '0;
            Down_Clear <= '0;
            Door_Open  <= 1'b0;
            Moving     <= 1'b0;
            mask_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            Floor      <= floor_n;
            Dir        <= dir_n;
            move_cnt_q <= move_cnt_n;
            door_cnt_q <= door_cnt_n;
            Up_Clear   <= up_clr_n;
            Down_Clear <= dn_clr_n;
            Door_Open  <= (state_n == S_DOOR);
            Moving     <= (state_n == S_MOVE);
            mask_q     <= (|up_clr_n) || (|dn_clr_n) || (|Up_Clear) || (|Down_Clear);
        end
    end
endmodule
